sha256_block_padder: RTL and testbench



---
 rtl/sha256_block_padder_if.sv | 26 ++
 rtl/sha256_block_padder.sv | 163 ++++++++++++++++
 tb/tb_sha256_block_padder.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_block_padder_if.sv
// Word-memory read port and padded-word output stream of sha256_block_padder.
//   mem_clk/mem_we/mem_addr/mem_read_data : single-port word memory (read only)
//   w_valid/w_data/w_first/w_blk_end/w_last/w_ready : padded-word stream
//   master: the padder; slave: memory model + hash core (consumer)
interface sha256_block_padder_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_first;
    logic        w_blk_end;
    logic        w_last;
    logic        w_ready;

    modport master (
        output mem_clk, mem_we, mem_addr, w_valid, w_data, w_first, w_blk_end, w_last,
        input  mem_read_data, w_ready
    );

    modport slave (
        input  mem_clk, mem_we, mem_addr, w_valid, w_data, w_first, w_blk_end, w_last,
        output mem_read_data, w_ready
    );
endinterface

// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: reads NUM_OF_WORDS words from word memory starting at
// message_addr, appends 0x80000000, zero fill and the 64-bit bit length, and
// streams the result one word per valid/ready transfer in 16-word blocks.
//   clk, reset_n      : clock, synchronous active-low reset
//   start             : begin a job (sampled in IDLE only)
//   message_addr      : word address of message word 0 (latched on start)
//   busy, done        : job in progress / one-cycle completion pulse
//   bus (master)      : memory read port and padded-word output stream
module sha256_block_padder #(
    parameter int unsigned NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        busy,
    output logic        done,
    sha256_block_padder_if.master bus
);

    localparam int unsigned BLOCKS   = (NUM_OF_WORDS + 18) / 16;
    localparam int unsigned TOTAL    = 16 * BLOCKS;
    localparam int unsigned IW       = $clog2(TOTAL + 1);
    localparam logic [IW-1:0] N_IDX    = IW'(NUM_OF_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD = 32'(NUM_OF_WORDS * 32);

    typedef enum logic [1:0] {IDLE, FETCH, PAD, FINISH} state_t;

    state_t        state_q, state_d;
    logic [15:0]   base_q;
    logic [IW-1:0] rd_idx_q;     // next message index to read
    logic [IW-1:0] out_idx_q;    // next padded index to load into the output register
    logic          req_q;        // address presented to memory this cycle
    logic          rdv_q;        // memory data returning this cycle
    logic [31:0]   buf_q [2];
    logic [1:0]    cnt_q;

    logic          start_c, active_c, fetching_c, have_c, load_c, pop_c, xfer_c, issue_c;
    logic [2:0]    occ_c;
    logic [31:0]   head_c, word_c;
    logic [15:0]   addr_c;
    logic [IW-1:0] rd_idx_d;

    assign bus.mem_clk = clk;
    assign bus.mem_we  = 1'b0;

    // Next-state, read issue and output-load decisions.
    always_comb begin
        state_d    = state_q;
        start_c    = (state_q == IDLE) && start;
        active_c   = (state_q == FETCH) || (state_q == PAD);
        fetching_c = out_idx_q < N_IDX;
        xfer_c     = bus.w_valid && bus.w_ready;
        head_c     = (cnt_q != 2'd0) ? buf_q[0] : bus.mem_read_data;
        have_c     = fetching_c ? ((cnt_q != 2'd0) || rdv_q) : (out_idx_q <= LAST_IDX);
        load_c     = active_c && (!bus.w_valid || bus.w_ready) && have_c;
        pop_c      = load_c && fetching_c;
        // Words owed to the buffer once this cycle's consumption is accounted for.
        occ_c      = 3'(cnt_q) + 3'(rdv_q) + 3'(req_q) - 3'(pop_c);
        issue_c    = 1'b0;
        addr_c     = base_q + 16'(rd_idx_q);
        rd_idx_d   = rd_idx_q + IW'(1);
        word_c     = 32'd0;

        if (fetching_c)                 word_c = head_c;
        else if (out_idx_q == N_IDX)    word_c = PAD_WORD;
        else if (out_idx_q == LAST_IDX) word_c = LEN_WORD;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FETCH;
                    issue_c  = 1'b1;
                    addr_c   = message_addr;
                    rd_idx_d = IW'(1);
                end
            end
            FETCH: begin
                issue_c = (rd_idx_q < N_IDX) && (occ_c < 3'd2);
                if (load_c && (out_idx_q == N_IDX - IW'(1))) state_d = PAD;
            end
            PAD: begin
                if (xfer_c && bus.w_last) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Read pipeline, prefetch buffer and output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            base_q        <= 16'd0;
            rd_idx_q      <= '0;
            out_idx_q     <= '0;
            req_q         <= 1'b0;
            rdv_q         <= 1'b0;
            buf_q[0]      <= 32'd0;
            buf_q[1]      <= 32'd0;
            cnt_q         <= 2'd0;
            bus.mem_addr  <= 16'd0;
            bus.w_valid   <= 1'b0;
            bus.w_data    <= 32'd0;
            bus.w_first   <= 1'b0;
            bus.w_blk_end <= 1'b0;
            bus.w_last    <= 1'b0;
        end else begin
            busy  <= (state_d == FETCH) || (state_d == PAD);
            done  <= (state_d == FINISH);
            req_q <= issue_c;
            rdv_q <= req_q;

            if (issue_c) begin
                bus.mem_addr <= addr_c;
                rd_idx_q     <= rd_idx_d;
            end

            if (start_c) begin
                base_q    <= message_addr;
                out_idx_q <= '0;
                cnt_q     <= 2'd0;
            end else begin
                // Occupancy never exceeds two, so a push only meets cnt_q of 0 or 1.
                case ({rdv_q, pop_c})
                    2'b10: begin
                        buf_q[cnt_q[0]] <= bus.mem_read_data;
                        cnt_q           <= cnt_q + 2'd1;
                    end
                    2'b01: begin
                        buf_q[0] <= buf_q[1];
                        cnt_q    <= cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (cnt_q != 2'd0) buf_q[0] <= bus.mem_read_data;
                    end
                    default: ;
                endcase

                if (load_c) begin
                    bus.w_valid   <= 1'b1;
                    bus.w_data    <= word_c;
                    bus.w_first   <= (out_idx_q[3:0] == 4'd0);
                    bus.w_blk_end <= (out_idx_q[3:0] == 4'd15);
                    bus.w_last    <= (out_idx_q == LAST_IDX);
                    out_idx_q     <= out_idx_q + IW'(1);
                end else if (xfer_c) begin
                    bus.w_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Bench for sha256_block_padder: three instances (N=20, 14, 13) share a word
// memory model; each scenario task checks the stream against a padding model.
module tb_sha256_block_padder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic [15:0] message_addr = 16'd0;
    logic        w_ready = 1'b0;
    logic [2:0]  busy_v, done_v;

    always #5 clk = ~clk;

    sha256_block_padder_if bus20();
    sha256_block_padder_if bus14();
    sha256_block_padder_if bus13();

    sha256_block_padder #(.NUM_OF_WORDS(20)) u_dut20 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .message_addr(message_addr),
        .busy(busy_v[0]), .done(done_v[0]), .bus(bus20.master));
    sha256_block_padder #(.NUM_OF_WORDS(14)) u_dut14 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .message_addr(message_addr),
        .busy(busy_v[1]), .done(done_v[1]), .bus(bus14.master));
    sha256_block_padder #(.NUM_OF_WORDS(13)) u_dut13 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .message_addr(message_addr),
        .busy(busy_v[2]), .done(done_v[2]), .bus(bus13.master));

    assign bus20.w_ready = w_ready;
    assign bus14.w_ready = w_ready;
    assign bus13.w_ready = w_ready;

    logic [31:0] mem [0:65535];

    always @(posedge clk) begin
        bus20.mem_read_data <= mem[bus20.mem_addr];
        bus14.mem_read_data <= mem[bus14.mem_addr];
        bus13.mem_read_data <= mem[bus13.mem_addr];
    end

    int          sel = 0;
    logic        o_valid, o_first, o_blk, o_last, o_we, o_busy, o_done;
    logic [31:0] o_data;
    logic [15:0] o_addr;

    always_comb begin
        case (sel)
            1: begin
                o_valid = bus14.w_valid; o_data = bus14.w_data; o_first = bus14.w_first;
                o_blk = bus14.w_blk_end; o_last = bus14.w_last; o_addr = bus14.mem_addr;
                o_we = bus14.mem_we; o_busy = busy_v[1]; o_done = done_v[1];
            end
            2: begin
                o_valid = bus13.w_valid; o_data = bus13.w_data; o_first = bus13.w_first;
                o_blk = bus13.w_blk_end; o_last = bus13.w_last; o_addr = bus13.mem_addr;
                o_we = bus13.mem_we; o_busy = busy_v[2]; o_done = done_v[2];
            end
            default: begin
                o_valid = bus20.w_valid; o_data = bus20.w_data; o_first = bus20.w_first;
                o_blk = bus20.w_blk_end; o_last = bus20.w_last; o_addr = bus20.mem_addr;
                o_we = bus20.mem_we; o_busy = busy_v[0]; o_done = done_v[0];
            end
        endcase
    end

    int          total = 0;
    int          bad = 0;
    int          nwords [3] = '{20, 14, 13};
    logic [31:0] obs [0:63];
    logic [2:0]  obs_flags [0:63];
    int          obs_cnt;
    logic [31:0] seed_seq [0:31];

    localparam logic [31:0] SEED = 32'h0123_4675;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
        int s;
        s = k % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    // Padded word at index idx of an n-word message stored at base.
    function automatic logic [31:0] ref_word(input int n, input logic [15:0] base, input int idx);
        int          tot;
        logic [15:0] a;
        tot = 16 * ((n + 18) / 16);
        if (idx < n) begin
            a = base + 16'(idx);
            return mem[a];
        end
        if (idx == n) return 32'h8000_0000;
        if (idx == tot - 1) return 32'(n * 32);
        return 32'd0;
    endfunction

    task automatic fill_seed(input logic [15:0] base, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            mem[a] = rotl(SEED, i);
        end
    endtask

    task automatic fill_random(input logic [15:0] base, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            mem[a] = $urandom;
        end
    endtask

    // Runs one job on instance k and checks every cycle against the model.
    task automatic run_job(input int k, input logic [15:0] base, input int ready_pct,
                           input int restart_at);
        int          n, tot, c, xfers, last_c, first_c;
        bit          done_seen, prev_stall, restarted;
        logic [31:0] pd, exp_w;
        logic [2:0]  pf, exp_f;
        logic [15:0] prev_addr, offs;
        n = nwords[k];
        tot = 16 * ((n + 18) / 16);
        sel = k;
        @(negedge clk);
        start_v[k] = 1'b1;
        message_addr = base;
        w_ready = 1'b0;
        @(negedge clk);
        start_v[k] = 1'b0;
        c = 1; xfers = 0; last_c = -1; first_c = -1;
        done_seen = 0; prev_stall = 0; restarted = 0;
        pd = 32'd0; pf = 3'd0; prev_addr = base;
        obs_cnt = 0;
        while (!done_seen && c < 600) begin
            start_v[k] = 1'b0;
            if (restart_at >= 0 && xfers == restart_at && !restarted) begin
                start_v[k] = 1'b1;
                message_addr = ~base;
                restarted = 1;
            end
            w_ready = ($urandom % 100) < 32'(ready_pct);

            total++;
            if (o_we !== 1'b0) begin bad++; $display("FAIL mem_we: got %b want 0", o_we); end

            if (c == 1) begin
                total++;
                if (o_addr !== base) begin
                    bad++; $display("FAIL first_addr: got %h want %h", o_addr, base);
                end
            end else if (o_addr !== prev_addr) begin
                offs = o_addr - base;
                total++;
                if (o_addr !== prev_addr + 16'd1 || offs >= 16'(n)) begin
                    bad++; $display("FAIL addr_seq: got %h after %h (base %h n %0d)", o_addr, prev_addr, base, n);
                end
            end
            prev_addr = o_addr;

            if (prev_stall) begin
                total++;
                if (o_valid !== 1'b1 || o_data !== pd || {o_first, o_blk, o_last} !== pf) begin
                    bad++; $display("FAIL stall_hold: got v=%b %h %b want v=1 %h %b", o_valid, o_data, {o_first, o_blk, o_last}, pd, pf);
                end
            end

            if (o_valid && first_c < 0) first_c = c;

            if (o_done) begin
                done_seen = 1;
                total++;
                if (last_c < 0 || c != last_c + 1) begin
                    bad++; $display("FAIL done_time: got cycle %0d want %0d", c, last_c + 1);
                end
            end else begin
                total++;
                if (o_busy !== 1'b1) begin bad++; $display("FAIL busy: got %b want 1 at cycle %0d", o_busy, c); end
            end

            if (o_valid && w_ready && !o_done) begin
                exp_w = ref_word(n, base, xfers);
                exp_f = {xfers % 16 == 0, xfers % 16 == 15, xfers == tot - 1};
                total++;
                if (xfers >= tot || o_data !== exp_w || {o_first, o_blk, o_last} !== exp_f) begin
                    bad++; $display("FAIL word[%0d]: got %h %b want %h %b", xfers, o_data, {o_first, o_blk, o_last}, exp_w, exp_f);
                end
                if (xfers < 64) begin
                    obs[xfers] = o_data;
                    obs_flags[xfers] = {o_first, o_blk, o_last};
                end
                if (o_last) last_c = c;
                xfers++;
            end
            prev_stall = o_valid && !w_ready;
            pd = o_data;
            pf = {o_first, o_blk, o_last};
            @(negedge clk);
            c++;
        end
        start_v[k] = 1'b0;
        w_ready = 1'b0;
        obs_cnt = xfers;

        total++;
        if (!done_seen) begin bad++; $display("FAIL done_timeout: got none want pulse within 600 cycles"); end
        total++;
        if (xfers != tot) begin bad++; $display("FAIL xfer_count: got %0d want %0d", xfers, tot); end
        total++;
        if (prev_addr !== base + 16'(n - 1)) begin
            bad++; $display("FAIL last_addr: got %h want %h", prev_addr, base + 16'(n - 1));
        end
        if (ready_pct >= 100) begin
            total++;
            if (first_c != 3 || last_c != 2 + tot) begin
                bad++; $display("FAIL latency: got first %0d last %0d want 3 %0d", first_c, last_c, 2 + tot);
            end
        end
        total++;
        if ({o_busy, o_done, o_valid} !== 3'b000) begin
            bad++; $display("FAIL post_done: got busy/done/valid %b want 000", {o_busy, o_done, o_valid});
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({o_busy, o_done, o_addr, o_valid, o_data, o_first, o_blk, o_last, o_we} !== 55'd0) begin
            bad++; $display("FAIL reset_state: got busy=%b done=%b addr=%h v=%b d=%h f=%b%b%b we=%b want all 0",
                            o_busy, o_done, o_addr, o_valid, o_data, o_first, o_blk, o_last, o_we);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_seed_stream();
        logic [2:0] ef;
        fill_seed(16'h0000, 20);
        run_job(0, 16'h0000, 100, -1);
        for (int i = 0; i < 32; i++) seed_seq[i] = obs[i];
        total++;
        if (obs_cnt != 32) begin bad++; $display("FAIL seed_count: got %0d want 32", obs_cnt); end
        total++;
        if (obs[0] !== 32'h0123_4675 || obs[1] !== 32'h0246_8CEA || obs[19] !== rotl(SEED, 19)) begin
            bad++; $display("FAIL seed_msg: got %h %h %h want 01234675 02468cea %h", obs[0], obs[1], obs[19], rotl(SEED, 19));
        end
        total++;
        if (obs[20] !== 32'h8000_0000 || obs[31] !== 32'h0000_0280) begin
            bad++; $display("FAIL seed_pad: got %h %h want 80000000 00000280", obs[20], obs[31]);
        end
        for (int i = 21; i <= 30; i++) begin
            total++;
            if (obs[i] !== 32'd0) begin bad++; $display("FAIL seed_zero[%0d]: got %h want 0", i, obs[i]); end
        end
        for (int i = 0; i < 32; i++) begin
            ef = {i == 0 || i == 16, i == 15 || i == 31, i == 31};
            total++;
            if (obs_flags[i] !== ef) begin bad++; $display("FAIL seed_flags[%0d]: got %b want %b", i, obs_flags[i], ef); end
        end
    endtask

    task automatic test_backpressure();
        fill_seed(16'h0000, 20);
        run_job(0, 16'h0000, 50, -1);
        for (int i = 0; i < 32; i++) begin
            total++;
            if (obs[i] !== seed_seq[i]) begin bad++; $display("FAIL bp_word[%0d]: got %h want %h", i, obs[i], seed_seq[i]); end
        end
    endtask

    task automatic test_n14();
        fill_random(16'h0100, 14);
        run_job(1, 16'h0100, 100, -1);
        total++;
        if (obs_cnt != 32 || obs[14] !== 32'h8000_0000 || obs[31] !== 32'h0000_01C0) begin
            bad++; $display("FAIL n14_pad: got cnt %0d %h %h want 32 80000000 000001c0", obs_cnt, obs[14], obs[31]);
        end
        for (int i = 15; i <= 30; i++) begin
            total++;
            if (obs[i] !== 32'd0) begin bad++; $display("FAIL n14_zero[%0d]: got %h want 0", i, obs[i]); end
        end
    endtask

    task automatic test_n13();
        logic [2:0] ef;
        fill_random(16'h2345, 13);
        run_job(2, 16'h2345, 60, -1);
        total++;
        if (obs_cnt != 16 || obs[13] !== 32'h8000_0000 || obs[14] !== 32'd0 || obs[15] !== 32'h0000_01A0) begin
            bad++; $display("FAIL n13_pad: got cnt %0d %h %h %h want 16 80000000 0 000001a0", obs_cnt, obs[13], obs[14], obs[15]);
        end
        for (int i = 0; i < 16; i++) begin
            ef = {i == 0, i == 15, i == 15};
            total++;
            if (obs_flags[i] !== ef) begin bad++; $display("FAIL n13_flags[%0d]: got %b want %b", i, obs_flags[i], ef); end
        end
    endtask

    task automatic test_restart_ignored();
        fill_random(16'h0040, 20);
        run_job(0, 16'h0040, 100, 5);
    endtask

    task automatic test_reset_mid_job();
        int xfers, c;
        sel = 0;
        fill_random(16'h0300, 20);
        @(negedge clk);
        start_v[0] = 1'b1;
        message_addr = 16'h0300;
        @(negedge clk);
        start_v[0] = 1'b0;
        w_ready = 1'b1;
        xfers = 0; c = 0;
        while (xfers < 10 && c < 100) begin
            if (o_valid) xfers++;
            @(negedge clk);
            c++;
        end
        total++;
        if (xfers != 10) begin bad++; $display("FAIL rst_mid_progress: got %0d want 10", xfers); end
        w_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if ({o_busy, o_done, o_addr, o_valid, o_data, o_first, o_blk, o_last} !== 54'd0) begin
            bad++; $display("FAIL rst_mid_state: got busy=%b done=%b addr=%h v=%b d=%h f=%b%b%b want all 0",
                            o_busy, o_done, o_addr, o_valid, o_data, o_first, o_blk, o_last);
        end
        reset_n = 1'b1;
        @(negedge clk);
        run_job(0, 16'h0300, 70, -1);
    endtask

    task automatic test_random_jobs();
        int          k;
        logic [15:0] base;
        for (int r = 0; r < 6; r++) begin
            k = int'($urandom % 3);
            base = (r == 0) ? 16'hFFF8 : 16'($urandom);
            fill_random(base, nwords[k]);
            run_job(k, base, 30 + int'($urandom % 71), -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        test_reset();
        test_seed_stream();
        test_backpressure();
        test_n14();
        test_n13();
        test_restart_ignored();
        test_reset_mid_job();
        test_random_jobs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
